// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK_WAIT
    } rxState_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // A FIFO entry is {frame_err, parity_err, data}.
    function automatic int entryWidth(input int dataBits);
        return dataBits + 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO: the head entry is presented whenever the FIFO is non-empty.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             popReq,
    output logic [WIDTH-1:0] headData,
    output logic             notEmpty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic             pop;
    logic             doPush;

    always_comb begin
        notEmpty = (count != '0);
        full     = (count == (AW+1)'(DEPTH));
        pop      = popReq && notEmpty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        doPush   = push && (!full || pop);
        headData = notEmpty ? mem[rdPtr] : '0;
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with 3-sample majority vote, parity/framing/break
// detection and a show-ahead receive FIFO.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_parity_err,
    output logic                 rd_frame_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy,
    output rxState_t             dbgState
);

    localparam int H  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DATA_BITS);
    localparam int EW = entryWidth(DATA_BITS);

    rxState_t             state;
    logic                 rxMeta, rxs;
    logic [CW-1:0]        c;
    logic [NW-1:0]        n;
    logic                 stopN;
    logic                 s0, s1;
    logic [DATA_BITS-1:0] sh;
    logic                 acc, parErr, frameErr, allZero;
    logic                 vote, atSample, atEnd, lastStop, isBreak, push;
    logic                 fifoFull;
    logic [EW-1:0]        pushData, headData;

    always_comb begin
        vote     = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
        atSample = tick && (c == CW'(H + 1));
        atEnd    = tick && (c == CW'(OVERSAMPLE - 1));
        lastStop = (stopN == 1'(STOP_BITS - 1));
        // Break is decided on the first stop bit, before any completion push.
        isBreak  = (state == S_STOP) && atSample && !stopN && allZero && !vote;
        push     = (state == S_STOP) && atSample && lastStop && !isBreak;
        pushData = {frameErr | ~vote, parErr, sh};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rxMeta    <= 1'b1;
            rxs       <= 1'b1;
            c         <= '0;
            n         <= '0;
            stopN     <= 1'b0;
            s0        <= 1'b1;
            s1        <= 1'b1;
            sh        <= '0;
            acc       <= 1'b0;
            parErr    <= 1'b0;
            frameErr  <= 1'b0;
            allZero   <= 1'b1;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            break_det <= 1'b0;
        end else begin
            rxMeta    <= rx;
            rxs       <= rxMeta;
            busy      <= (state != S_IDLE);
            overrun   <= push && fifoFull && !rd_ready;
            break_det <= isBreak;

            if (tick && state != S_IDLE && state != S_BRK_WAIT) begin
                c <= atEnd ? '0 : c + 1'b1;
            end
            if (tick && c == CW'(H - 1)) s0 <= rxs;
            if (tick && c == CW'(H))     s1 <= rxs;

            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        c        <= '0;
                        n        <= '0;
                        stopN    <= 1'b0;
                        sh       <= '0;
                        acc      <= 1'b0;
                        parErr   <= 1'b0;
                        frameErr <= 1'b0;
                        allZero  <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (atSample && vote) begin
                        state <= S_IDLE;
                    end else if (atEnd) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (atSample) begin
                        sh      <= {vote, sh[DATA_BITS-1:1]};
                        acc     <= acc ^ vote;
                        allZero <= allZero & ~vote;
                    end
                    if (atEnd) begin
                        if (n == NW'(DATA_BITS - 1)) begin
                            n     <= '0;
                            state <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            n <= n + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (atSample) begin
                        parErr  <= (PARITY == PAR_EVEN) ? (acc ^ vote) : ~(acc ^ vote);
                        allZero <= allZero & ~vote;
                    end
                    if (atEnd) begin
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    // The last stop bit ends at its sample point so the next start edge is caught.
                    if (atSample) begin
                        frameErr <= frameErr | ~vote;
                        if (isBreak) begin
                            state <= S_BRK_WAIT;
                        end else if (lastStop) begin
                            state <= S_IDLE;
                        end
                    end else if (atEnd) begin
                        stopN <= 1'b1;
                    end
                end
                S_BRK_WAIT: begin
                    if (rxs) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH(EW),
        .DEPTH(FIFO_DEPTH)
    ) uFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pushData (pushData),
        .popReq   (rd_ready),
        .headData (headData),
        .notEmpty (rd_valid),
        .full     (fifoFull)
    );

    assign {rd_frame_err, rd_parity_err, rd_data} = headData;
    assign dbgState = state;

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, next generation of the project's serial receive path. Oversamples a synchronised RX line, recovers frames of configurable data width, parity mode and stop-bit count, and votes each bit from three mid-bit samples. Detects parity, framing and break conditions. Delivers bytes through a valid/ready interface backed by a small receive FIFO, with overrun reporting.

## Interface
- DATA_BITS, 8, data bits per frame, legal 5..9.
- OVERSAMPLE, 16, `tick` pulses per bit period, even, legal 8..64.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits per frame, legal 1 or 2.
- FIFO_DEPTH, 4, receive FIFO entries, power of two, at least 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  oversample enable, one-cycle pulse at OVERSAMPLE × baud.
- rx  in  1  asynchronous serial line, idle high.
- rd_valid  out  1  FIFO head holds a frame.
- rd_ready  in  1  consumer accepts the head this cycle.
- rd_data  out  DATA_BITS  received data, LSB = first bit on the line.
- rd_parity_err  out  1  parity mismatch for the head frame; 0 when PARITY=0.
- rd_frame_err  out  1  a stop bit was sampled 0 for the head frame.
- overrun  out  1  one-cycle pulse: a completed frame was dropped because the FIFO was full.
- break_det  out  1  one-cycle pulse: break detected.
- busy  out  1  FSM not in IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser, reset value 1. All line decisions use the synchronised value `rxs`.
- Bit counter `c` (0..OVERSAMPLE-1) advances only on `tick`. At c = OVERSAMPLE-1 it wraps to 0 and the bit ends.
- Sample points are c = H-1, H and H+1, where H = OVERSAMPLE/2. The bit value is the majority of the three samples.
- IDLE: in any cycle with `rxs` = 0, clear c, clear the shift register and parity accumulator, and go to START. No `tick` is needed.
- START: at c = H+1, if the voted value is 1 (false start or glitch), go to IDLE. Otherwise go to DATA at the end of the bit.
- DATA: shift the voted bit into the MSB and shift right, giving LSB-first order. XOR the bit into the parity accumulator. The bit index `n` counts 0..DATA_BITS-1. After the last bit, go to PARITY if PARITY≠0, else STOP.
- PARITY: compute the error flag. Even mode: error = acc ^ bit. Odd mode: error = ~(acc ^ bit).
- STOP: one bit period per stop bit. Any stop bit voted 0 sets frame_err.
  - At c = H+1 of the last stop bit, the frame is complete. Go to IDLE at that point, not at the end of the bit, so the receiver can resynchronise to the next start edge.
- Break: a frame where all data bits, the parity bit (if present) and the first stop bit are all 0.
  - Pulse `break_det` and write nothing to the FIFO.
  - Go to BRK_WAIT, which returns to IDLE on the first cycle with `rxs` = 1.
- FIFO entry format: {frame_err, parity_err, data}. Show-ahead: `rd_*` reflect the head entry whenever `rd_valid` = 1.
  - A pop occurs when rd_valid & rd_ready.
  - A push occurs at frame completion, unless the frame is a break.
- Full FIFO: a push is dropped and `overrun` pulses, unless a pop happens in the same cycle. In that case the push is accepted and the count is unchanged. Stored entries are never overwritten.
- Empty FIFO: `rd_ready` is ignored. rd_data, rd_parity_err and rd_frame_err read as 0.
- Reset (at any time, including mid-frame): FSM to IDLE, counters 0, FIFO emptied, synchroniser set to 1.
  - Reset values of all outputs: rd_valid, rd_data, rd_parity_err, rd_frame_err, overrun, break_det and busy are all 0.

## Timing
- The synchroniser adds 2 cycles from an `rx` edge to `rxs`.
- A push registers on the frame-completion edge. `rd_valid` rises the next cycle.
- With `tick` every cycle, a frame completes (1 + DATA_BITS + P + STOP_BITS − 1)·OVERSAMPLE + H + 1 cycles after `rxs` falls, where P = 1 if parity is enabled, else 0.
- Pops are registered. `rd_valid`/`rd_data` update the cycle after a pop, so sustained throughput is 1 entry per cycle.
- `overrun` and `break_det` assert on the same edge as the attempted push or the break decision.
- `busy` is registered from the state register and is 1 in START, DATA, PARITY, STOP and BRK_WAIT.

## Structure
- Package `uart_pkg` holds:
  - state enum: IDLE, START, DATA, PARITY, STOP, BRK_WAIT;
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - a function returning the FIFO entry width (DATA_BITS+2).
- Sub-module `uart_rx_fifo`: synchronous show-ahead FIFO with push/pop/full/empty. It is parametrised by WIDTH and DEPTH and uses a count register of width log2(DEPTH)+1.
- Top level: synchroniser, FSM, counters, majority vote, parity accumulator and error logic.

## Test plan
- 8N1, OVERSAMPLE 16, tick every cycle, send 0xA5, rd_ready=1 → one pop with rd_data=0xA5, both error flags 0, no overrun.
- PARITY=1, send 0x3C with parity bit 1 → rd_data=0x3C, rd_parity_err=1. Repeat with parity bit 0 → rd_parity_err=0.
- `rx` low for 3 ticks, then high → FSM returns to IDLE, busy falls, no push.
- Send 0x55 with stop bit held 0 for a full bit period, then restore high → rd_data=0x55, rd_frame_err=1.
  - Separately: a single-tick glitch at sample H → majority rejects it and the data is correct.
- Hold `rx` low for 2 frame times → exactly one break_det pulse, no FIFO entry. After `rx` returns high, 0x12 is received normally.
- FIFO_DEPTH 4, rd_ready=0, send 0x01..0x05 → overrun pulses once on frame 5. Then drain → 0x01..0x04 in order.
  - Then assert reset mid-frame → all outputs 0, FIFO empty, and the next frame is received cleanly.
